// File: rtl/ifc_pkg.sv
// Shared helpers and types for the ifc_* method-handshake blocks.
package ifc_pkg;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Kept flat on ports so wrappers can reach each signal directly.
    typedef struct packed {
        logic en;
        logic rdy;
        logic data;
    } method_bit_t;

endpackage

// File: rtl/ifc_word_fifo.sv
// Small word FIFO with extra-MSB pointers; head is read straight from registered storage.
module ifc_word_fifo
    import ifc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             enq_en,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq_en,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = clog2_min1(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_enq;
    logic             do_deq;

    always_comb begin
        empty  = (wr_ptr == rd_ptr);
        full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_deq = deq_en && !empty;
        // A write into a full FIFO is allowed when the head leaves on the same edge.
        do_enq = enq_en && (!full || do_deq);
        head   = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_enq) begin
                mem[wr_ptr[AW-1:0]] <= enq_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ifc_bit_collector.sv
// Pulls single bits from the upstream get-method, packs them LSB-first into words
// and offers completed words through a FIFO-backed get-method.
module ifc_bit_collector
    import ifc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     in_rdy,
    input  logic                     in_data,
    output logic                     in_en,
    input  logic                     out_en,
    output logic                     out_rdy,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic [CNT_W-1:0]         word_cnt
);

    localparam int unsigned BW = $clog2(WIDTH);

    logic [WIDTH-2:0] shift;
    logic             last;
    logic             full;
    logic             empty;
    logic             full_eff;
    logic             enq_en;
    logic [WIDTH-1:0] enq_data;

    always_comb begin
        out_rdy  = !empty;
        last     = (bit_cnt == BW'(WIDTH - 1));
        full_eff = full && !(out_en && out_rdy);
        in_en    = in_rdy && !(last && full_eff);
        enq_en   = in_en && last;
        // The final bit goes straight into the word, so the top shift bit never needs storing.
        enq_data = {in_data, shift};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shift    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else if (in_en) begin
            if (last) begin
                bit_cnt  <= '0;
                word_cnt <= word_cnt + 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                for (int unsigned i = 0; i < WIDTH - 1; i++) begin
                    if (bit_cnt == BW'(i)) begin
                        shift[i] <= in_data;
                    end
                end
            end
        end
    end

    ifc_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .enq_en   (enq_en),
        .enq_data (enq_data),
        .deq_en   (out_en),
        .full     (full),
        .empty    (empty),
        .head     (out_data)
    );

endmodule
